// File: rtl/p08_div_pkg.sv
// p08_div_pkg: shared FSM states and sizing constants for the sequential divider.
package p08_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DIV_WIDTH_DEFAULT = 4;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH_DEFAULT);
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/p08_seq_divider_fs.sv
// p08_FS: one-bit full subtractor, the cell of the divider's trial-subtract chain.
module p08_FS (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);
  assign D = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

// File: rtl/p08_seq_divider.sv
// p08_seq_divider: unsigned restoring divider, one quotient bit per clock.
// Define P08_DIV_DBZ_EN to short-circuit divide-by-zero straight to DONE with dbz set.
module p08_seq_divider
  import p08_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);
  localparam int CW = cnt_w(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH:0] r_q, r_d, r_sh, t, b_ext;
  logic [WIDTH+1:0] bw;
  logic [WIDTH-1:0] q_q, q_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d;
  assign r_sh = (r_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
  assign b_ext = {1'b0, d_q};
  assign bw[0] = 1'b0;
  genvar i;
  for (i = 0; i <= WIDTH; i++) begin : g_sub
    p08_FS u_fs (.A(r_sh[i]), .B(b_ext[i]), .Bin(bw[i]), .D(t[i]), .Bout(bw[i+1]));
  end
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    q_d = q_q;
    d_d = d_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    if (state_q == RUN) begin
      r_d = bw[WIDTH+1] ? r_sh : t;
      q_d = {q_q[WIDTH-2:0], ~bw[WIDTH+1]};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = DONE;
        quo_d = q_d;
        rem_d = r_d[WIDTH-1:0];
        dbz_d = 1'b0;
      end
    end else if (start) begin
      state_d = RUN;
      r_d = '0;
      q_d = dividend;
      d_d = divisor;
      cnt_d = CW'(WIDTH - 1);
`ifdef P08_DIV_DBZ_EN
      if (divisor == '0) begin
        state_d = DONE;
        quo_d = '1;
        rem_d = dividend;
        dbz_d = 1'b1;
      end
`endif
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      q_q <= q_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign quotient = quo_q;
  assign remainder = rem_q;
  assign dbz = dbz_q;
endmodule

// File: tb/tb_p08_seq_divider.sv
// tb_p08_seq_divider: directed plus randomized checks against an arithmetic division model.
module tb_p08_seq_divider;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n, start, busy, done, dbz;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  int checks = 0;
  int errors = 0;
  int last_q = 0;
  int last_r = 0;
  always #5 clk = ~clk;
  p08_seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input int a, input int b);
    start = 1'b1;
    dividend = W'(a);
    divisor = W'(b);
  endtask
  task automatic run_to_done(input int a, input int b, input int inj);
    bit z;
    int lat;
    z = (b == 0);
    last_q = z ? (1 << W) - 1 : a / b;
    last_r = z ? a : a % b;
`ifdef P08_DIV_DBZ_EN
    lat = z ? 1 : W + 1;
`else
    lat = W + 1;
`endif
    for (int k = 1; k <= lat; k++) begin
      step();
      if (k == 1) start = 1'b0;
      if (inj != 0 && k == inj) issue(1, 1);
      if (inj != 0 && k == inj + 1) start = 1'b0;
      chk("busy", busy, k < lat);
      chk("done", done, k == lat);
    end
    chk("quotient", quotient, last_q);
    chk("remainder", remainder, last_r);
`ifdef P08_DIV_DBZ_EN
    chk("dbz", dbz, z);
`else
    chk("dbz", dbz, 0);
`endif
  endtask
  task automatic settle();
    step();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_q", quotient, last_q);
    chk("hold_r", remainder, last_r);
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    dividend = 4'd5;
    divisor = 4'd1;
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", dbz, 0);
    start = 1'b0;
    rst_n = 1'b1;
    step();
    issue(13, 3); run_to_done(13, 3, 0); settle();
    issue(15, 1); run_to_done(15, 1, 0);
    issue(2, 5); run_to_done(2, 5, 0); settle();
    issue(7, 0); run_to_done(7, 0, 0); settle();
    issue(9, 2); run_to_done(9, 2, 2); settle();
    issue(14, 3);
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) start = 1'b0;
      if (k == 3) rst_n = 1'b0;
    end
    step();
    rst_n = 1'b1;
    for (int k = 4; k <= 8; k++) begin
      chk("abort_done", done, 0);
      chk("abort_busy", busy, 0);
      chk("abort_q", quotient, 0);
      chk("abort_r", remainder, 0);
      step();
    end
    issue(14, 3); run_to_done(14, 3, 0); settle();
    for (int a = 0; a < (1 << W); a++)
      for (int b = 1; b < (1 << W); b++) begin
        issue(a, b);
        run_to_done(a, b, 0);
      end
    settle();
    for (int n = 0; n < 80; n++) begin
      int a, b, gap;
      a = $urandom_range(0, (1 << W) - 1);
      b = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, (1 << W) - 1);
      gap = $urandom_range(0, 2);
      issue(a, b);
      run_to_done(a, b, ($urandom_range(0, 3) == 0 && b != 0) ? 2 : 0);
      for (int g = 0; g < gap; g++) settle();
    end
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
